game_step_scheduler: RTL and testbench
======================================

// Module: game_step_scheduler
// PURPOSE
//   Consumes the single-cycle time_up tick of a free-running game timer and turns it
//   into game-step pulses. The pulse rate speeds up as the player advances levels.
//   Sits directly downstream of the timer bank and upstream of the game-logic FSM,
//   which advances one move per step pulse. Also provides start/pause/stop run control.
// PARAMETERS
//   LEVEL_W          3    width of level output
//   MAX_LEVEL        7    saturating top level (must be <= 2**LEVEL_W-1)
//   BASE_DIV         16   ticks per step at level 0
//   DIV_DEC          2    ticks removed from divisor per level
//   MIN_DIV          2    divisor floor (>=1)
//   STEPS_PER_LEVEL  20   steps required to advance one level
//   CNT_W            8    width of tick/step counters (must hold BASE_DIV, STEPS_PER_LEVEL)
// PORTS
//   clk       in   1        system clock; everything is on its rising edge
//   reset     in   1        synchronous, active-high reset
//   start     in   1        level; begins a run from IDLE
//   pause     in   1        level; holds the run while high
//   stop      in   1        level; aborts the run and returns to IDLE
//   tick      in   1        one-cycle pulse from the upstream timer's time_up
//   step      out  1        one-cycle registered game-step pulse
//   level_up  out  1        one-cycle pulse, coincident with the step that raised the level
//   level     out  LEVEL_W  current level
//   running   out  1        high in RUN
//   paused    out  1        high in PAUSE
// BEHAVIOUR
//   - Reset: state=IDLE; tick_cnt=0; step_cnt=0; level=0; step=level_up=running=paused=0.
//   - Priority each cycle: reset > stop > pause > start/tick.
//   - Divisor: div = (level*DIV_DEC >= BASE_DIV-MIN_DIV) ? MIN_DIV : BASE_DIV-level*DIV_DEC.
//     Product computed at CNT_W+LEVEL_W bits; no underflow.
//   - IDLE: ticks ignored, level holds its last value.
//     start=1 -> RUN next cycle; tick_cnt, step_cnt, level cleared.
//   - RUN, tick=1, tick_cnt==div-1: step=1 in the next cycle; tick_cnt=0; step_cnt++.
//     Otherwise tick=1 increments tick_cnt.
//     Latency: step rises exactly 1 cycle after the qualifying tick.
//   - RUN, step issued with step_cnt==STEPS_PER_LEVEL-1:
//     step_cnt=0; if level<MAX_LEVEL then level++ and level_up=1 (same cycle as step).
//     At MAX_LEVEL, step_cnt wraps with no level_up and level holds.
//     The new divisor applies from the next tick.
//   - RUN, pause=1: -> PAUSE; a tick in that same cycle is dropped.
//     In PAUSE, counters hold and ticks are dropped. pause=0 -> RUN next cycle.
//   - stop=1 in RUN/PAUSE: -> IDLE; any coincident tick is dropped; tick_cnt/step_cnt cleared;
//     level holds for score display.
//   - start in RUN/PAUSE is ignored. stop/pause in IDLE are ignored.
//   - Reset asserted mid-run: all state and outputs return to reset values on the next edge.
//   - step and level_up are never high for more than one cycle.
// CONFIGURATION
//   STEP_TURBO_EN defined:
//     adds input `turbo` (1 bit); while turbo=1 in RUN, div is forced to MIN_DIV.
//     Level progression is unchanged; tick_cnt>=div on entry counts as terminal
//     (step on the next tick).
//   Undefined: no turbo port; the divisor always follows level.
// TESTING
//   1. reset; start; 16 ticks -> single step 1 cycle after 16th tick, level=0, level_up=0.
//   2. 20 steps from level 0 -> level=1, level_up pulses with the 20th step;
//      next step needs 14 ticks.
//   3. RUN, 5 ticks, pause=1, 10 ticks, pause=0 -> paused=1 while held;
//      step after 11 further ticks.
//   4. drive to level 7 -> div=2; 20 more steps give no level_up, level stays 7.
//   5. tick coincident with stop after 15 ticks -> no step, IDLE, level held;
//      start -> level=0, 16 ticks for next step.
//   6. STEP_TURBO_EN, level 0, turbo=1 -> step every 2 ticks;
//      reset mid-run -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/game_step_scheduler.sv
//------------------------------------------------------------------------------
// Module      : game_step_scheduler
// Description : Turns the single-cycle tick of an upstream game timer into
//               game-step pulses whose rate increases with the player level.
//               Provides start / pause / stop run control.
//               Optional feature macro: STEP_TURBO_EN (adds a turbo input that
//               forces the fastest divisor while running).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module game_step_scheduler #(
  parameter int LEVEL_W         = 3,
  parameter int MAX_LEVEL       = 7,
  parameter int BASE_DIV        = 16,
  parameter int DIV_DEC         = 2,
  parameter int MIN_DIV         = 2,
  parameter int STEPS_PER_LEVEL = 20,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               tick,
`ifdef STEP_TURBO_EN
  input  logic               turbo,
`endif
  output logic               step,
  output logic               level_up,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               paused
);

  // The level*DIV_DEC product is formed wide enough that it can never wrap.
  localparam int                PROD_W   = CNT_W + LEVEL_W;
  localparam logic [PROD_W-1:0] DIV_SPAN = PROD_W'(BASE_DIV - MIN_DIV);
  localparam logic [CNT_W-1:0]  DIV_MIN  = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0]  DIV_BASE = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0]  STEP_TOP = CNT_W'(STEPS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]   step_cnt;

  logic [PROD_W-1:0]  lvl_prod;
  logic [CNT_W-1:0]   level_div;
  logic [CNT_W-1:0]   div;
  logic [CNT_W-1:0]   div_last;
  logic               tick_terminal;

  // Divisor for the current level (optionally overridden by turbo) and the
  // terminal-tick decision. ">=" rather than "==" so a counter already past a
  // freshly shortened divisor fires on the very next tick.
  always_comb begin
    lvl_prod = PROD_W'(level) * PROD_W'(DIV_DEC);
    if (lvl_prod >= DIV_SPAN) begin
      level_div = DIV_MIN;
    end else begin
      level_div = DIV_BASE - lvl_prod[CNT_W-1:0];
    end
    div = level_div;
`ifdef STEP_TURBO_EN
    if (turbo) begin
      div = DIV_MIN;
    end
`endif
    div_last      = div - CNT_W'(1);
    tick_terminal = (tick_cnt >= div_last);
  end

  // Run-control FSM, tick/step counters, level tracking and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      step_cnt <= '0;
      level    <= '0;
      step     <= 1'b0;
      level_up <= 1'b0;
      running  <= 1'b0;
      paused   <= 1'b0;
    end else begin
      step     <= 1'b0;
      level_up <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks are ignored here and level keeps the last score.
          if (start && !stop) begin
            state    <= RUN;
            running  <= 1'b1;
            paused   <= 1'b0;
            tick_cnt <= '0;
            step_cnt <= '0;
            level    <= '0;
          end
        end

        RUN: begin
          if (stop) begin
            state    <= IDLE;
            running  <= 1'b0;
            paused   <= 1'b0;
            tick_cnt <= '0;
            step_cnt <= '0;
          end else if (pause) begin
            state    <= PAUSE;
            running  <= 1'b0;
            paused   <= 1'b1;
          end else if (tick) begin
            if (tick_terminal) begin
              step     <= 1'b1;
              tick_cnt <= '0;
              if (step_cnt == STEP_TOP) begin
                step_cnt <= '0;
                if (level < LVL_TOP) begin
                  level    <= level + LEVEL_W'(1);
                  level_up <= 1'b1;
                end
              end else begin
                step_cnt <= step_cnt + CNT_W'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        PAUSE: begin
          // Counters hold and ticks are dropped while paused.
          if (stop) begin
            state    <= IDLE;
            running  <= 1'b0;
            paused   <= 1'b0;
            tick_cnt <= '0;
            step_cnt <= '0;
          end else if (!pause) begin
            state    <= RUN;
            running  <= 1'b1;
            paused   <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          paused  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_step_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_game_step_scheduler
// Description : Self-checking bench for game_step_scheduler. A behavioural
//               model counts ticks and steps directly from the game rules;
//               directed scenarios pin the model with literal expectations,
//               then a randomized phase runs against the model.
//               Honours STEP_TURBO_EN the same way as the design.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_game_step_scheduler;

  localparam int LEVEL_W = 3;
  localparam int MAX_LVL = 7;
  localparam int BASE    = 16;
  localparam int DEC     = 2;
  localparam int MINDIV  = 2;
  localparam int SPL     = 20;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               pause = 1'b0;
  logic               stop = 1'b0;
  logic               tick = 1'b0;
  logic               turbo = 1'b0;
  logic               step;
  logic               level_up;
  logic [LEVEL_W-1:0] level;
  logic               running;
  logic               paused;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: mode 0=idle 1=run 2=paused
  int m_mode = 0;
  int m_ticks = 0;
  int m_steps = 0;
  int m_level = 0;
  int m_step = 0;
  int m_lup = 0;

  game_step_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .tick     (tick),
`ifdef STEP_TURBO_EN
    .turbo    (turbo),
`endif
    .step     (step),
    .level_up (level_up),
    .level    (level),
    .running  (running),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  function automatic int ticks_per_step(input int lvl, input bit tb);
    int p;
    p = lvl * DEC;
`ifdef STEP_TURBO_EN
    if (tb) return MINDIV;
`endif
    if (p >= BASE - MINDIV) return MINDIV;
    return BASE - p;
  endfunction

  task automatic model_update(input bit r, input bit st, input bit pa, input bit sp,
                              input bit tk, input bit tb);
    m_step = 0;
    m_lup  = 0;
    if (r) begin
      m_mode = 0; m_ticks = 0; m_steps = 0; m_level = 0;
    end else if (m_mode == 0) begin
      if (st && !sp) begin
        m_mode = 1; m_ticks = 0; m_steps = 0; m_level = 0;
      end
    end else if (sp) begin
      m_mode = 0; m_ticks = 0; m_steps = 0;
    end else if (m_mode == 1) begin
      if (pa) begin
        m_mode = 2;
      end else if (tk) begin
        m_ticks = m_ticks + 1;
        if (m_ticks >= ticks_per_step(m_level, tb)) begin
          m_ticks = 0;
          m_step  = 1;
          m_steps = m_steps + 1;
          if (m_steps == SPL) begin
            m_steps = 0;
            if (m_level < MAX_LVL) begin
              m_level = m_level + 1;
              m_lup   = 1;
            end
          end
        end
      end
    end else begin
      if (!pa) m_mode = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic cycle(input bit r, input bit st, input bit pa, input bit sp, input bit tk);
    reset = r; start = st; pause = pa; stop = sp; tick = tk;
    @(posedge clk);
    model_update(r, st, pa, sp, tk, turbo);
    #1;
    vectors++;
    chk("step",     int'(step),     m_step);
    chk("level_up", int'(level_up), m_lup);
    chk("level",    int'(level),    m_level);
    chk("running",  int'(running),  int'(m_mode == 1));
    chk("paused",   int'(paused),   int'(m_mode == 2));
  endtask

  // Apply ticks until a step appears; reports ticks used and level_up on that step.
  task automatic ticks_to_step(output int n, output int lup);
    bit got;
    got = 0; n = 0; lup = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle(0, 0, 0, 0, 1);
      n++;
      if (step === 1'b1) begin
        got = 1;
        lup = int'(level_up);
      end
    end
    if (!got) begin
      miscompares++;
      $display("FAIL step_timeout: got no step after %0d ticks expected a step", n);
    end
  endtask

  initial begin
    int n, lup, lups;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("rst_level", int'(level), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_step", int'(step), 0);
    cycle(0, 0, 0, 0, 1);
    chk("idle_tick_ignored", int'(running), 0);

    // 1: start, first step after 16 ticks at level 0
    cycle(0, 1, 0, 0, 0);
    chk("t1_running", int'(running), 1);
    ticks_to_step(n, lup);
    chk("t1_ticks", n, 16);
    chk("t1_level_up", lup, 0);
    chk("t1_level", int'(level), 0);
    cycle(0, 0, 0, 0, 0);
    chk("t1_step_one_cycle", int'(step), 0);

    // 2: 20th step raises level; next step needs 14 ticks
    lups = 0;
    for (int i = 0; i < 19; i++) begin
      ticks_to_step(n, lup);
      lups += lup;
    end
    chk("t2_last_level_up", lup, 1);
    chk("t2_level_up_count", lups, 1);
    chk("t2_level", int'(level), 1);
    ticks_to_step(n, lup);
    chk("t2_ticks_l1", n, 14);

    // 3: pause holds tick count
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 0, 1);
      chk("t3_paused", int'(paused), 1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("t3_resumed", int'(running), 1);
    ticks_to_step(n, lup);
    chk("t3_ticks_after_pause", n, 11);

    // 4: reach level 7, div=2, no further level_up
    for (int i = 0; i < 200 && level != 3'd7; i++) ticks_to_step(n, lup);
    chk("t4_level", int'(level), 7);
    ticks_to_step(n, lup);
    chk("t4_ticks_l7", n, 2);
    lups = 0;
    for (int i = 0; i < 20; i++) begin
      ticks_to_step(n, lup);
      lups += lup;
    end
    chk("t4_no_level_up", lups, 0);
    chk("t4_level_hold", int'(level), 7);

    // 5: stop holds level, coincident tick dropped; start clears level
    cycle(0, 0, 0, 1, 1);
    chk("t5_stop_step", int'(step), 0);
    chk("t5_stop_level", int'(level), 7);
    chk("t5_stop_running", int'(running), 0);
    cycle(0, 1, 0, 0, 0);
    chk("t5_start_level", int'(level), 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    chk("t5_stop16_step", int'(step), 0);
    chk("t5_stop16_running", int'(running), 0);
    cycle(0, 1, 0, 0, 0);
    ticks_to_step(n, lup);
    chk("t5_restart_ticks", n, 16);

`ifdef STEP_TURBO_EN
    // 6: turbo forces div=2; count past div fires on next tick; reset mid-run
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    turbo = 1'b1;
    ticks_to_step(n, lup);
    chk("t6_turbo_entry", n, 1);
    ticks_to_step(n, lup);
    chk("t6_turbo_ticks", n, 2);
    cycle(1, 0, 0, 0, 1);
    chk("t6_rst_step", int'(step), 0);
    chk("t6_rst_running", int'(running), 0);
    chk("t6_rst_level", int'(level), 0);
    turbo = 1'b0;
`endif

    // Randomized phase against the model
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      bit r, st, pa, sp, tk;
      r  = ($urandom_range(0, 999) == 0);
      sp = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 19) == 0);
      pa = (pause && $urandom_range(0, 7) != 0) || ($urandom_range(0, 59) == 0);
      tk = ($urandom_range(0, 2) != 0);
`ifdef STEP_TURBO_EN
      if ($urandom_range(0, 149) == 0) turbo = ~turbo;
`endif
      cycle(r, st, pa, sp, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
